// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit.
package arm_ctrl_pkg;

    typedef logic [3:0] state_t;

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] IMM_DP  = 2'b00;
    localparam logic [1:0] IMM_MEM = 2'b01;
    localparam logic [1:0] IMM_BR  = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    // Unsupported data-processing commands fall back to ADD.
    function automatic logic [1:0] dp_alu(input logic [3:0] cmd);
        logic [1:0] r;
        case (cmd)
            4'b0100: r = ALU_ADD;
            4'b0010: r = ALU_SUB;
            4'b0000: r = ALU_AND;
            4'b1100: r = ALU_ORR;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/arm_mc_controller_cond.sv
// NZCV flag register, condition check and latched cond_ok.
module cond_unit
    import arm_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_cond,
    input  logic [3:0] i_alu_flags,
    input  logic       i_cond_load,
    input  logic [1:0] i_flag_w,
    output logic       o_cond_ok
);

    logic [3:0] r_flags;
    logic       r_cond_ok;
    logic       w_n, w_z, w_c, w_v;
    logic       w_met;

    assign {w_n, w_z, w_c, w_v} = r_flags;
    assign o_cond_ok = r_cond_ok;

    always_comb begin
        w_met = 1'b0;
        unique case (i_cond)
            COND_EQ: w_met = w_z;
            COND_NE: w_met = ~w_z;
            COND_CS: w_met = w_c;
            COND_CC: w_met = ~w_c;
            COND_MI: w_met = w_n;
            COND_PL: w_met = ~w_n;
            COND_VS: w_met = w_v;
            COND_VC: w_met = ~w_v;
            COND_HI: w_met = w_c & ~w_z;
            COND_LS: w_met = ~w_c | w_z;
            COND_GE: w_met = ~(w_n ^ w_v);
            COND_LT: w_met = w_n ^ w_v;
            COND_GT: w_met = ~w_z & ~(w_n ^ w_v);
            COND_LE: w_met = w_z | (w_n ^ w_v);
            COND_AL: w_met = 1'b1;
            default: w_met = 1'b0;
        endcase
    end

    // Flag writes are gated by the cond_ok latched for this instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flags   <= 4'b0000;
            r_cond_ok <= 1'b0;
        end else begin
            if (i_cond_load)
                r_cond_ok <= w_met;
            if (i_flag_w[1] && r_cond_ok)
                r_flags[3:2] <= i_alu_flags[3:2];
            if (i_flag_w[0] && r_cond_ok)
                r_flags[1:0] <= i_alu_flags[1:0];
        end
    end

endmodule

// File: rtl/arm_mc_controller.sv
// Multicycle ARM control FSM: decodes the IR and drives datapath controls.
module arm_mc_controller
    import arm_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic [1:0]   ResultSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic         RegWrite,
    output logic [1:0]   ALUControl
);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] w_cond;
    logic [1:0] w_op;
    logic [5:0] w_funct;
    logic [3:0] w_rd;
    logic [1:0] w_dp_alu;
    logic       w_exec;
    logic [1:0] w_flag_w;
    logic       w_cond_ok;
    logic       w_pcw, w_memw, w_irw, w_regw;
    logic       w_unused_rn;

    assign w_cond      = Instr[31:28];
    assign w_op        = Instr[27:26];
    assign w_funct     = Instr[25:20];
    assign w_rd        = Instr[15:12];
    assign w_unused_rn = ^Instr[19:16];
    assign w_dp_alu    = dp_alu(w_funct[4:1]);

    assign w_exec = (r_state == S_EXECR) || (r_state == S_EXECI);
    assign w_flag_w[1] = w_exec && w_funct[0];
    assign w_flag_w[0] = w_exec && w_funct[0] &&
                         (w_dp_alu == ALU_ADD || w_dp_alu == ALU_SUB);

    cond_unit u_cond (
        .clk         (clk),
        .reset       (reset),
        .i_cond      (w_cond),
        .i_alu_flags (ALUFlags),
        .i_cond_load (r_state == S_DECODE),
        .i_flag_w    (w_flag_w),
        .o_cond_ok   (w_cond_ok)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_FETCH;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                unique case (w_op)
                    2'b01:   w_next = S_MEMADR;
                    2'b00:   w_next = w_funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   w_next = S_BRANCH;
                    default: w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = w_funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXECR,
            S_EXECI:  w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pcw      = 1'b0;
        w_memw     = 1'b0;
        w_irw      = 1'b0;
        w_regw     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ImmSrc     = IMM_DP;
        RegSrc     = 2'b00;
        ALUControl = ALU_ADD;
        unique case (r_state)
            S_FETCH: begin
                w_irw     = 1'b1;
                w_pcw     = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALURES;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALURES;
                ImmSrc    = (w_op == 2'b01) ? IMM_MEM :
                            (w_op == 2'b10) ? IMM_BR : IMM_DP;
                RegSrc[0] = (w_op == 2'b10);
                RegSrc[1] = (w_op == 2'b01) && !w_funct[0];
            end
            S_MEMADR: begin
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_MEM;
                ALUControl = w_funct[3] ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                w_regw    = w_cond_ok;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                w_memw = w_cond_ok;
            end
            S_EXECR: ALUControl = w_dp_alu;
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = w_dp_alu;
            end
            // Rd=R15 turns the write-back into a PC load.
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                if (w_rd == 4'd15)
                    w_pcw = w_cond_ok;
                else
                    w_regw = w_cond_ok;
            end
            S_BRANCH: begin
                ImmSrc    = IMM_BR;
                ALUSrcB   = SRCB_IMM;
                ResultSrc = RES_ALURES;
                w_pcw     = w_cond_ok;
            end
            default: ;
        endcase
    end

    assign PCWrite  = w_pcw  & reset;
    assign MemWrite = w_memw & reset;
    assign IRWrite  = w_irw  & reset;
    assign RegWrite = w_regw & reset;

endmodule

// File: tb/tb_arm_mc_controller.sv
// Directed plus random instruction streams checked against a per-instruction model.
module tb_arm_mc_controller;

    logic         clk;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, AdrSrc, MemWrite, IRWrite;
    logic [1:0]   ResultSrc;
    logic         ALUSrcA;
    logic [1:0]   ALUSrcB, ImmSrc, RegSrc;
    logic         RegWrite;
    logic [1:0]   ALUControl;

    int total = 0;
    int bad   = 0;
    logic [3:0] m_flags;

    arm_mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .RegWrite   (RegWrite),
        .ALUControl (ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] obs_vec();
        return {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, RegSrc, RegWrite, ALUControl};
    endfunction

    // Odd codes below 1110 are the inverse of the preceding even code.
    function automatic bit cond_model(logic [3:0] c, logic [3:0] f);
        bit n, z, cy, v, base;
        {n, z, cy, v} = f;
        if (c == 4'd14) return 1'b1;
        if (c == 4'd15) return 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            default: base = !z && (n == v);
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic [1:0] alu_model(logic [3:0] cmd);
        if (cmd == 4'b0010) return 2'b01;
        if (cmd == 4'b0000) return 2'b10;
        if (cmd == 4'b1100) return 2'b11;
        return 2'b00;
    endfunction

    function automatic int len_model(logic [31:0] ins);
        case (ins[27:26])
            2'b01:   return ins[20] ? 5 : 4;
            2'b00:   return 4;
            2'b10:   return 3;
            default: return 2;
        endcase
    endfunction

    // Expected control word for cycle k of an instruction.
    function automatic logic [15:0] exp_out(logic [31:0] ins, int k, bit ok);
        logic pcw, adr, memw, irw, srca, regw;
        logic [1:0] res, srcb, imm, rsrc, alu, op;
        logic [5:0] fn;
        op = ins[27:26];
        fn = ins[25:20];
        {pcw, adr, memw, irw, srca, regw} = '0;
        {res, srcb, imm, rsrc, alu} = '0;
        if (k == 0) begin
            pcw = 1; irw = 1; srca = 1; srcb = 2'b10; res = 2'b10;
        end else if (k == 1) begin
            srca = 1; srcb = 2'b10; res = 2'b10;
            imm = (op == 2'b01) ? 2'b01 : (op == 2'b10) ? 2'b10 : 2'b00;
            rsrc = {op == 2'b01 && !fn[0], op == 2'b10};
        end else if (op == 2'b01) begin
            if (k == 2) begin
                srcb = 2'b01; imm = 2'b01; alu = fn[3] ? 2'b00 : 2'b01;
            end else if (k == 3) begin
                adr = 1; memw = !fn[0] && ok;
            end else begin
                res = 2'b01; regw = ok;
            end
        end else if (op == 2'b00) begin
            if (k == 2) begin
                srcb = fn[5] ? 2'b01 : 2'b00; alu = alu_model(fn[4:1]);
            end else begin
                pcw  = ok && ins[15:12] == 4'd15;
                regw = ok && ins[15:12] != 4'd15;
            end
        end else begin
            imm = 2'b10; srcb = 2'b01; res = 2'b10; pcw = ok;
        end
        return {pcw, adr, memw, irw, res, srca, srcb, imm, rsrc, regw, alu};
    endfunction

    // Entered and left just after a falling edge with the DUT in FETCH.
    task automatic run_instr(input string tag, input logic [31:0] ins,
                             input logic [3:0] af);
        bit ok;
        int n;
        logic [1:0] a;
        Instr    = ins[31:12];
        ALUFlags = af;
        ok = cond_model(ins[31:28], m_flags);
        n  = len_model(ins);
        for (int k = 0; k < n; k++) begin
            #1;
            chk($sformatf("%s.c%0d", tag, k), 32'(obs_vec()),
                32'(exp_out(ins, k, ok)));
            @(negedge clk);
        end
        if (ins[27:26] == 2'b00 && ins[20] && ok) begin
            m_flags[3:2] = af[3:2];
            a = alu_model(ins[24:21]);
            if (a == 2'b00 || a == 2'b01) m_flags[1:0] = af[1:0];
        end
        chk({tag, ".flags"}, 32'(dut.u_cond.r_flags), 32'(m_flags));
    endtask

    initial begin
        logic [31:0] ins;
        reset    = 1'b0;
        Instr    = '0;
        ALUFlags = '0;
        m_flags  = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst.pcw", 32'(PCWrite), 0);
        chk("rst.irw", 32'(IRWrite), 0);
        chk("rst.flags", 32'(dut.u_cond.r_flags), 0);
        @(negedge clk);
        reset = 1'b1;

        run_instr("add", 32'hE0821003, 4'b1111);
        run_instr("subs", 32'hE2500001, 4'b0100);
        run_instr("beq", 32'h0A000000, 4'b0000);
        run_instr("bne", 32'h1A000000, 4'b0000);
        run_instr("ldr", 32'hE5954008, 4'b0000);
        run_instr("adds", 32'hE0900000, 4'b0011);
        run_instr("streq", 32'h05854008, 4'b0000);
        run_instr("ands", 32'hE0100000, 4'b1011);
        run_instr("ands2", 32'hE0100000, 4'b0100);
        run_instr("movpc", 32'hE080F000, 4'b0000);
        run_instr("nop", 32'hEC000000, 4'b0000);

        ins      = 32'hE5854008;
        Instr    = ins[31:12];
        ALUFlags = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("strrst.c%0d", k), 32'(obs_vec()),
                32'(exp_out(ins, k, 1'b1)));
            @(negedge clk);
        end
        #1;
        chk("strrst.memw1", 32'(MemWrite), 1);
        reset = 1'b0;
        #1;
        chk("strrst.memw0", 32'(MemWrite), 0);
        chk("strrst.state", 32'(dut.r_state), 0);
        chk("strrst.flags", 32'(dut.u_cond.r_flags), 0);
        m_flags = '0;
        @(negedge clk);
        reset = 1'b1;
        run_instr("postrst", 32'hE0821003, 4'b0000);

        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 3) == 0) ins[31:28] = 4'hE;
            run_instr($sformatf("rnd%0d", i), ins, 4'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arm_mc_controller.md
# arm_mc_controller

Multicycle control unit for the 32-bit ARM core. It decodes the fetched instruction, holds the NZCV flag register, evaluates the condition field, and sequences the shared datapath (single memory, single ALU, register file) through fetch, decode, execute and write-back states. Every enable, select and ALUControl signal consumed by the multicycle datapath comes from this block.

## Interface
- Parameters: none; encodings are fixed in the shared package.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; state → FETCH, flags → 0000
- Instr  in  20  Instr[31:12] from the instruction register: cond[31:28], op[27:26], funct[25:20], Rd[15:12]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- PCWrite  out  1  load PC
- AdrSrc  out  1  memory address: 0 = PC, 1 = ALU result register
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  load instruction register
- ResultSrc  out  2  00 ALUOut reg, 01 Data reg, 10 ALUResult (live)
- ALUSrcA  out  1  0 = register A, 1 = PC
- ALUSrcB  out  2  00 register B, 01 ExtImm, 10 constant 4
- ImmSrc  out  2  00 8-bit DP imm, 01 12-bit mem offset, 10 24-bit branch
- RegSrc  out  2  [0] RA1 = R15, [1] RA2 = Rd (STR)
- RegWrite  out  1  register file write
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR

## Operation
- Moore FSM; states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional). → DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, ImmSrc/RegSrc from op. cond_ok register loaded from condition check. Next: op=01 → MEMADR; op=00 & funct[5]=0 → EXECR; op=00 & funct[5]=1 → EXECI; op=10 → BRANCH; op=11 → FETCH (NOP).
- MEMADR: ALUSrcB=01, ImmSrc=01, ALUControl=ADD if funct[3](U)=1 else SUB. funct[0](L)=1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc=1 → MEMWB. MEMWB: ResultSrc=01, RegWrite=cond_ok → FETCH. MEMWR: AdrSrc=1, MemWrite=cond_ok → FETCH.
- EXECR / EXECI: ALUSrcB=00 / 01, ALUControl from funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, other ADD. → ALUWB.
- ALUWB: ResultSrc=00, RegWrite=cond_ok; if Rd=15 also PCWrite=cond_ok, RegWrite=0 → FETCH.
- BRANCH: ImmSrc=10, ALUSrcB=01, ALUControl=ADD, ResultSrc=10, PCWrite=cond_ok → FETCH.
- Flags: at EXECR/EXECI exit, if funct[0](S)=1 and cond_ok: N,Z always updated; C,V updated only for ADD/SUB.
- Condition (from stored flags): EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE per ARM; 1110 AL → 1; 1111 → 0.
- All outputs not listed for a state are 0.

## Timing
- State register and flags update on rising clk; outputs combinational from state + Instr + cond_ok.
- Cycles per instruction: LDR 5, STR 4, DP 4, B 3, op=11 2.
- cond_ok sampled at DECODE exit; flag update in EXEC never affects the same instruction's write-back.
- Reset low at any time: state → FETCH and flags → 0000 immediately; while low PCWrite, MemWrite, RegWrite, IRWrite forced 0. First FETCH occurs on first edge after release.
- Failed condition: same state sequence and cycle count, write enables suppressed.

## Structure
- Package arm_ctrl_pkg: state enum, ALUControl codes, ImmSrc/ResultSrc/ALUSrcB codes, cond codes.
- Sub-module cond_unit: flags register, condition evaluation, cond_ok flop, FlagW gating. FSM and decoder stay in the top.

## Test plan
- Reset release, Instr=ADD R1,R2,R3 (E0821003) → FETCH,DECODE,EXECR,ALUWB; RegWrite=1 in ALUWB only; ALUControl=00.
- SUBS R0,R0,#1 with ALUFlags=0100 in EXECI → flags=0100; following BEQ (0A......) → PCWrite=1 in BRANCH; BNE → PCWrite=0, still 3 cycles.
- LDR R4,[R5,#8] (E5954008) → MEMADR,MEMRD,MEMWB; AdrSrc=1 in MEMRD, ResultSrc=01 and RegWrite=1 in MEMWB.
- STR with cond=0000 and Z=0 → 4 cycles, MemWrite never asserted.
- ANDS with ALUFlags=1011 from flags 0011 → flags=1011 N,Z only; C,V keep prior 11.
- Reset asserted during MEMWR → MemWrite drops immediately; state FETCH, flags 0000 after release.
